approx_mul_err_monitor: RTL and testbench

Windowed error-statistics monitor placed directly downstream of the `unsigned_exchange_8x8_*` approximate multipliers. It consumes each operand pair (x, y) together with the approximate product z, recomputes the exact product, and accumulates per-window metrics: sum of error distances, maximum error distance and erroneous-sample count. Results are presented once per window on a valid/ready output handshake, which supports on-silicon or emulation characterisation of each approximate multiplier variant.

---
 rtl/approx_mul_pkg.sv | 15 +
 rtl/approx_ed_calc.sv | 23 ++
 rtl/approx_mul_err_monitor.sv | 134 +++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate-multiplier characterisation monitors.
package approx_mul_pkg;

  // Monitor control states: wait for start, collect a window, flush the pipeline, present results.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

endpackage

// File: rtl/approx_ed_calc.sv
// Error-distance calculator: compares an approximate product against the exact x*y.
module approx_ed_calc
  import approx_mul_pkg::*;
(
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  input  logic [PROD_W-1:0] z,
  output logic [PROD_W-1:0] ed,
  output logic              nonzero
);

  logic [PROD_W-1:0] exact;
  logic [PROD_W:0]   diff;

  // Exact product, signed difference and its magnitude; the magnitude never exceeds 16 bits.
  always_comb begin
    exact   = PROD_W'(x) * PROD_W'(y);
    diff    = {1'b0, exact} - {1'b0, z};
    ed      = diff[PROD_W] ? PROD_W'(-diff) : diff[PROD_W-1:0];
    nonzero = (exact != z);
  end

endmodule

// File: rtl/approx_mul_err_monitor.sv
// Windowed error-statistics monitor: accumulates sum/max error distance and error count
// over 2^WIN_LOG2 samples and presents them on a valid/ready handshake.
module approx_mul_err_monitor
  import approx_mul_pkg::*;
#(
  parameter int WIN_LOG2 = 8,
  parameter int ACC_W    = 16 + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     x,
  input  logic [OP_W-1:0]     y,
  input  logic [PROD_W-1:0]   z,
  output logic                busy,
  output logic                done_valid,
  input  logic                done_ready,
  output logic [ACC_W-1:0]    sum_ed,
  output logic [PROD_W-1:0]   max_ed,
  output logic [WIN_LOG2:0]   err_cnt
);

  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << WIN_LOG2) - 1);

  mon_state_t        state;
  mon_state_t        state_nxt;
  logic [CNT_W-1:0]  sample_cnt;
  logic              accept;
  logic              win_clear;

  logic              s1_valid;
  logic [OP_W-1:0]   s1_x;
  logic [OP_W-1:0]   s1_y;
  logic [PROD_W-1:0] s1_z;

  logic              s2_valid;
  logic [PROD_W-1:0] s2_ed;
  logic              s2_nz;

  logic [PROD_W-1:0] calc_ed;
  logic              calc_nz;

  assign in_ready   = (state == RUN);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done_valid = (state == DONE);
  assign accept     = in_valid & in_ready;
  assign win_clear  = (state == IDLE) && start;

  approx_ed_calc u_ed_calc (
    .x       (s1_x),
    .y       (s1_y),
    .z       (s1_z),
    .ed      (calc_ed),
    .nonzero (calc_nz)
  );

  // Next-state logic; the final accept closes the window, and DONE waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && (sample_cnt == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nxt = DONE;
      DONE:    if (done_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sample counter, cleared when a window opens and stepped by each accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sample_cnt <= '0;
    else if (win_clear) sample_cnt <= '0;
    else if (accept)    sample_cnt <= sample_cnt + CNT_W'(1);
  end

  // S1: capture the operand pair and approximate product on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_z     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_x <= x;
        s1_y <= y;
        s1_z <= z;
      end
    end
  end

  // S2: register the error distance and the erroneous-sample flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_ed    <= '0;
      s2_nz    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_ed <= calc_ed;
        s2_nz <= calc_nz;
      end
    end
  end

  // S3: fold each sample into the window statistics; these hold steady outside updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (win_clear) begin
      sum_ed  <= '0;
      max_ed  <= '0;
      err_cnt <= '0;
    end else if (s2_valid) begin
      sum_ed  <= sum_ed + ACC_W'(s2_ed);
      if (s2_ed > max_ed) max_ed <= s2_ed;
      err_cnt <= err_cnt + CNT_W'(s2_nz);
    end
  end

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Self-checking bench for approx_mul_err_monitor: a 4-sample window instance and a
// 256-sample window instance, checked against a plain-arithmetic window model.
module tb_approx_mul_err_monitor;

  logic        clk;
  logic        rst_n;
  logic        start2, start8;
  logic        in_valid;
  logic        done_ready;
  logic [7:0]  x, y;
  logic [15:0] z;

  logic        in_ready2, busy2, done_valid2;
  logic [17:0] sum2;
  logic [15:0] max2;
  logic [2:0]  cnt2;

  logic        in_ready8, busy8, done_valid8;
  logic [23:0] sum8;
  logic [15:0] max8;
  logic [8:0]  cnt8;

  int          check_count = 0;
  int          pass_count  = 0;
  bit          sel8        = 0;

  logic [7:0]  sx [256];
  logic [7:0]  sy [256];
  logic [15:0] sz [256];

  longint      exp_sum;
  int          exp_max;
  int          exp_cnt;

  approx_mul_err_monitor #(.WIN_LOG2(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .x(x), .y(y), .z(z), .busy(busy2), .done_valid(done_valid2), .done_ready(done_ready),
    .sum_ed(sum2), .max_ed(max2), .err_cnt(cnt2)
  );

  approx_mul_err_monitor #(.WIN_LOG2(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(in_valid), .in_ready(in_ready8),
    .x(x), .y(y), .z(z), .busy(busy8), .done_valid(done_valid8), .done_ready(done_ready),
    .sum_ed(sum8), .max_ed(max8), .err_cnt(cnt8)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic logic cur_ready();
    return sel8 ? in_ready8 : in_ready2;
  endfunction
  function automatic logic cur_busy();
    return sel8 ? busy8 : busy2;
  endfunction
  function automatic logic cur_done();
    return sel8 ? done_valid8 : done_valid2;
  endfunction
  function automatic logic [31:0] cur_sum();
    return sel8 ? 32'(sum8) : 32'(sum2);
  endfunction
  function automatic logic [31:0] cur_max();
    return sel8 ? 32'(max8) : 32'(max2);
  endfunction
  function automatic logic [31:0] cur_cnt();
    return sel8 ? 32'(cnt8) : 32'(cnt2);
  endfunction

  // Window model: statistics from the definition of error distance.
  task automatic model_reset();
    exp_sum = 0;
    exp_max = 0;
    exp_cnt = 0;
  endtask

  task automatic model_add(input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] zv);
    int e;
    e = int'(xv) * int'(yv) - int'(zv);
    if (e < 0) e = -e;
    exp_sum += e;
    if (e > exp_max) exp_max = e;
    if (e != 0) exp_cnt++;
  endtask

  // mode 0: mixed exact/near/random z, mode 1: all exact, mode 2: every sample erroneous.
  task automatic fill_samples(input int n, input int mode);
    int p, off, pick;
    for (int i = 0; i < n; i++) begin
      sx[i] = 8'($urandom);
      sy[i] = 8'($urandom);
      p     = int'(sx[i]) * int'(sy[i]);
      off   = int'($urandom_range(1, 300));
      pick  = (mode == 0) ? int'($urandom_range(0, 3)) : ((mode == 1) ? 0 : 1);
      case (pick)
        0:       sz[i] = 16'(p);
        1:       sz[i] = 16'((p > 32767) ? p - off : p + off);
        2:       sz[i] = 16'((p >= off) ? p - off : p + off);
        default: sz[i] = 16'($urandom);
      endcase
    end
  endtask

  task automatic start_window();
    @(negedge clk);
    if (sel8) start8 = 1'b1;
    else      start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start8 = 1'b0;
    checkOutput("busy_after_start", cur_busy(), 1);
    checkOutput("in_ready_in_run", cur_ready(), 1);
    checkOutput("sum_cleared", cur_sum(), 0);
    checkOutput("max_cleared", cur_max(), 0);
    checkOutput("cnt_cleared", cur_cnt(), 0);
    model_reset();
  endtask

  // Offer samples from the arrays; a sample counts only when in_ready is high while offered.
  task automatic applyStimulus(input int n, input bit toggle);
    int idx = 0;
    int cyc = 0;
    while (idx < n) begin
      if (cyc > 4 * n + 20) begin
        checkOutput("accept_timeout", 32'(idx), 32'(n));
        break;
      end
      if (toggle && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        x = 8'($urandom);
        y = 8'($urandom);
        z = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        x = sx[idx];
        y = sy[idx];
        z = sz[idx];
        if (cur_ready()) begin
          model_add(sx[idx], sy[idx], sz[idx]);
          idx++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Called one negedge after the final accept; garbage offered during drain must be ignored.
  task automatic wait_done(input string name);
    int k = 0;
    checkOutput({name, "_in_ready_closed"}, cur_ready(), 0);
    while (!cur_done() && k < 20) begin
      in_valid = 1'b1;
      x = 8'($urandom);
      y = 8'($urandom);
      z = 16'($urandom);
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    checkOutput({name, "_done_latency"}, 32'(k), 3);
    checkOutput({name, "_busy_at_done"}, cur_busy(), 0);
    checkOutput({name, "_in_ready_done"}, cur_ready(), 0);
    checkOutput({name, "_sum_ed"}, cur_sum(), 32'(exp_sum));
    checkOutput({name, "_max_ed"}, cur_max(), 32'(exp_max));
    checkOutput({name, "_err_cnt"}, cur_cnt(), 32'(exp_cnt));
  endtask

  task automatic release_done(input string name);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    checkOutput({name, "_done_dropped"}, cur_done(), 0);
    checkOutput({name, "_idle_busy"}, cur_busy(), 0);
  endtask

  // Main sequence.
  initial begin
    rst_n      = 1'b0;
    start2     = 1'b0;
    start8     = 1'b0;
    in_valid   = 1'b0;
    done_ready = 1'b0;
    x          = '0;
    y          = '0;
    z          = '0;
    model_reset();

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready2, 0);
    checkOutput("rst_busy", busy2, 0);
    checkOutput("rst_done_valid", done_valid2, 0);
    checkOutput("rst_sum", 32'(sum2), 0);
    checkOutput("rst_max", 32'(max2), 0);
    checkOutput("rst_cnt", 32'(cnt2), 0);
    checkOutput("rst8_busy", busy8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed window from the known vectors.
    sel8 = 0;
    sx[0] = 8'd3;   sy[0] = 8'd5;   sz[0] = 16'd15;
    sx[1] = 8'd255; sy[1] = 8'd255; sz[1] = 16'd65000;
    sx[2] = 8'd2;   sy[2] = 8'd2;   sz[2] = 16'd10;
    sx[3] = 8'd0;   sy[3] = 8'd9;   sz[3] = 16'd0;
    start_window();
    applyStimulus(4, 0);
    wait_done("directed");
    checkOutput("directed_sum_const", 32'(sum2), 31);
    checkOutput("directed_max_const", 32'(max2), 25);
    checkOutput("directed_cnt_const", 32'(cnt2), 2);

    // Consumer stalls in DONE while start is asserted; results must hold.
    for (int i = 0; i < 5; i++) begin
      start2 = 1'b1;
      @(negedge clk);
      checkOutput("hold_done_valid", done_valid2, 1);
      checkOutput("hold_in_ready", in_ready2, 0);
      checkOutput("hold_sum", 32'(sum2), 32'(exp_sum));
      checkOutput("hold_max", 32'(max2), 32'(exp_max));
      checkOutput("hold_cnt", 32'(cnt2), 32'(exp_cnt));
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    start2     = 1'b0;
    checkOutput("handshake_done_dropped", done_valid2, 0);
    checkOutput("handshake_start_ignored", busy2, 0);
    @(negedge clk);
    checkOutput("still_idle", busy2, 0);

    // Gapped in_valid: only real handshakes count.
    fill_samples(4, 0);
    start_window();
    applyStimulus(4, 1);
    wait_done("toggle");
    release_done("toggle");

    // Random windows, one of them with the consumer always ready.
    for (int r = 0; r < 6; r++) begin
      fill_samples(4, 0);
      start_window();
      applyStimulus(4, (r % 2) == 1);
      if (r == 2) done_ready = 1'b1;
      wait_done("random");
      if (r == 2) begin
        @(negedge clk);
        done_ready = 1'b0;
        checkOutput("ready_high_one_cycle", done_valid2, 0);
      end else begin
        release_done("random");
      end
    end

    // Erroneous window followed immediately by an exact one.
    fill_samples(4, 2);
    start_window();
    applyStimulus(4, 0);
    wait_done("errors");
    release_done("errors");
    fill_samples(4, 1);
    start_window();
    applyStimulus(4, 0);
    wait_done("exact_after_err");
    checkOutput("exact_after_err_cnt_zero", 32'(cnt2), 0);
    release_done("exact_after_err");

    // Abort mid-window with reset; the next window must carry no residue.
    fill_samples(4, 2);
    start_window();
    applyStimulus(2, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy2, 0);
    checkOutput("abort_in_ready", in_ready2, 0);
    checkOutput("abort_sum", 32'(sum2), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_cnt", 32'(cnt2), 0);
    checkOutput("abort_max", 32'(max2), 0);
    fill_samples(4, 1);
    start_window();
    applyStimulus(4, 0);
    wait_done("post_abort");
    checkOutput("post_abort_sum_zero", 32'(sum2), 0);
    release_done("post_abort");

    // Full-scale 256-sample window: worst-case error on every sample.
    sel8 = 1;
    for (int i = 0; i < 256; i++) begin
      sx[i] = 8'd255;
      sy[i] = 8'd255;
      sz[i] = 16'd0;
    end
    start_window();
    applyStimulus(256, 0);
    wait_done("full_scale");
    checkOutput("full_scale_sum_const", 32'(sum8), 16646400);
    checkOutput("full_scale_max_const", 32'(max8), 65025);
    checkOutput("full_scale_cnt_const", 32'(cnt8), 256);
    release_done("full_scale");

    fill_samples(256, 0);
    start_window();
    applyStimulus(256, 1);
    wait_done("random256");
    release_done("random256");

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
